// File: rtl/fft_out_reorder_if.sv
// Sample bus for the FFT output reorder buffer: bit-reversed samples in,
// natural-order samples out.
interface fft_out_reorder_if #(
  parameter int DATA_W = 17,
  parameter int LOG2N  = 5
);
  logic                     valid_i;
  logic signed [DATA_W-1:0] data_in_r;
  logic signed [DATA_W-1:0] data_in_i;
  logic                     valid_o;
  logic                     sop_o;
  logic [LOG2N-1:0]         idx_o;
  logic signed [DATA_W-1:0] data_out_r;
  logic signed [DATA_W-1:0] data_out_i;

  modport master (
    output valid_i, data_in_r, data_in_i,
    input  valid_o, sop_o, idx_o, data_out_r, data_out_i
  );

  modport slave (
    input  valid_i, data_in_r, data_in_i,
    output valid_o, sop_o, idx_o, data_out_r, data_out_i
  );
endinterface

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: stores each FFT frame at bit-reversed addresses
// and streams it back out in natural frequency order.
module fft_out_reorder #(
  parameter int DATA_W = 17,
  parameter int N      = 32,
  parameter int LOG2N  = 5
) (
  input logic              clk,
  input logic              rst,
  fft_out_reorder_if.slave bus
);

  typedef logic [2*DATA_W-1:0] word_t;

  word_t            mem [2*N];
  logic [LOG2N-1:0] wcnt;
  logic [LOG2N-1:0] rcnt;
  logic             wbank;
  logic             rbank;
  logic             read_active;
  logic             launch;
  logic [LOG2N:0]   waddr;
  logic [LOG2N:0]   raddr;
  word_t            rd_word;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = a[LOG2N-1-b];
    return r;
  endfunction

  assign launch  = bus.valid_i && (wcnt == LOG2N'(N-1));
  assign waddr   = {wbank, bitrev(wcnt)};
  assign raddr   = {rbank, rcnt};
  assign rd_word = mem[raddr];

  // RAM contents survive reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && bus.valid_i) mem[waddr] <= {bus.data_in_r, bus.data_in_i};
  end

  // A launch outranks the end of the current read so frames chain without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt        <= '0;
      wbank       <= 1'b0;
      rcnt        <= '0;
      rbank       <= 1'b0;
      read_active <= 1'b0;
    end else begin
      if (bus.valid_i) begin
        wcnt <= wcnt + LOG2N'(1);
        if (launch) wbank <= ~wbank;
      end
      if (launch) begin
        rbank       <= wbank;
        rcnt        <= '0;
        read_active <= 1'b1;
      end else if (read_active) begin
        rcnt <= rcnt + LOG2N'(1);
        if (rcnt == LOG2N'(N-1)) read_active <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.valid_o    <= 1'b0;
      bus.sop_o      <= 1'b0;
      bus.idx_o      <= '0;
      bus.data_out_r <= '0;
      bus.data_out_i <= '0;
    end else if (read_active) begin
      bus.valid_o    <= 1'b1;
      bus.sop_o      <= (rcnt == '0);
      bus.idx_o      <= rcnt;
      bus.data_out_r <= rd_word[2*DATA_W-1:DATA_W];
      bus.data_out_i <= rd_word[DATA_W-1:0];
    end else begin
      bus.valid_o <= 1'b0;
      bus.sop_o   <= 1'b0;
    end
  end

endmodule
